hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2: cycles the IF/ID flush is held after a redirect, covering fetch latency; legal range 1..7.
REQ-002 SHALL have parameter MC_TIMEOUT, default 40: maximum MC_WAIT cycles before a timeout.
REQ-003 SHALL have parameter PERF_W, default 16: width of the stall counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  in  1  core clock.
REQ-006 rst_ni  in  1  async active-low reset.
REQ-007 insert_bubble_i  in  1  load-use/branch hazard from the stall detector (onebit_sig_e).
REQ-008 mc_start_i  in  1  multicycle op (div/FPU) enters IE this cycle.
REQ-009 mc_done_i  in  1  multicycle result valid.
REQ-010 dmem_req_i, dmem_we_i, dmem_gnt_i, dmem_rvalid_i  in  1 each  IMEM-stage data bus handshake.
REQ-011 redirect_i  in  1  taken branch/jump resolved in IE.
REQ-012 trap_i  in  1  exception/interrupt accepted.
REQ-013 stall_if_o, stall_id_o, stall_ie_o, stall_imem_o  out  1 each  hold the stage register.
REQ-014 bubble_ie_o, bubble_imem_o, bubble_wb_o  out  1 each  inject a NOP into the stage register.
REQ-015 flush_if_id_o, flush_ie_o  out  1 each  kill the stage contents.
REQ-016 state_o  out  2  current hc_state_e; mc_timeout_o  out  1  sticky error; stall_cnt_o  out  PERF_W  stall-cycle count.

Function
REQ-017 SHALL implement FSM hc_state_e with states RUN, MC_WAIT, MEM_WAIT and FLUSH; outputs SHALL be combinational from state and inputs.
REQ-018 Priority in RUN SHALL be: trap_i > redirect_i > memory stall > multicycle stall > insert_bubble_i.
REQ-019 RUN with trap_i or redirect_i SHALL assert flush_if_id_o and flush_ie_o, load the flush counter with FLUSH_DEPTH-1 and go to FLUSH; if FLUSH_DEPTH=1, it SHALL stay in RUN.
REQ-020 FLUSH SHALL assert flush_if_id_o each cycle, decrement the counter and return to RUN at 0; trap_i arriving in FLUSH SHALL reload the counter.
REQ-021 A memory stall SHALL be dmem_req_i & ~dmem_gnt_i, or a granted load (dmem_we_i=0) whose dmem_rvalid_i is absent in the cycle after grant; either condition SHALL enter MEM_WAIT.
REQ-022 A load_pend flag SHALL set on a granted load and clear on dmem_rvalid_i; a granted load with rvalid in the next cycle SHALL cause no stall.
REQ-023 MEM_WAIT SHALL assert stall_if/id/ie/imem_o and bubble_wb_o, and SHALL exit to RUN in the cycle dmem_gnt_i (store) or dmem_rvalid_i (load) is seen, with no stall in that cycle.
REQ-024 RUN with mc_start_i & ~mc_done_i SHALL go to MC_WAIT; mc_done_i in the same cycle as mc_start_i SHALL cause no stall.
REQ-025 MC_WAIT SHALL assert stall_if/id/ie_o and bubble_imem_o, and SHALL return to RUN on mc_done_i.
REQ-026 In MC_WAIT, a 6-bit cycle counter SHALL increment; on reaching MC_TIMEOUT it SHALL set mc_timeout_o (sticky until reset) and force a return to RUN.
REQ-027 RUN with insert_bubble_i only SHALL assert stall_if_o, stall_id_o and bubble_ie_o for that cycle, with no state change.
REQ-028 trap_i or redirect_i arriving in MEM_WAIT or MC_WAIT SHALL be latched into a pending flag and served as a REQ-019 flush in the first RUN cycle; pending trap SHALL take precedence over pending redirect.
REQ-029 stall_cnt_o SHALL increment on each cycle stall_if_o=1 and SHALL saturate at all-ones.

Reset
REQ-030 Asserting rst_ni SHALL immediately set the state to RUN and clear load_pend, pending flags, the flush counter, the MC counter, mc_timeout_o and stall_cnt_o.
REQ-031 During reset, all stall, bubble and flush outputs SHALL be 0 and state_o SHALL be RUN; reset mid-wait SHALL abandon the outstanding transaction.

Structure
REQ-032 hc_state_e and the MC counter width SHALL live in core_pkg; onebit_sig_e SHALL come from common_pkg.
REQ-033 A single sub-module, hc_sat_counter, SHALL implement the saturating perf counter; all other logic SHALL be inline.

Verification
REQ-034 lw granted cycle 0, rvalid cycle 3 -> MEM_WAIT in cycles 1-2, stall_imem_o=1, RUN in cycle 3, stall_cnt_o=2.
REQ-035 insert_bubble_i for 1 cycle in RUN -> stall_if/id_o=1 and bubble_ie_o=1 for exactly 1 cycle, state_o stays RUN.
REQ-036 redirect_i at cycle 5 with FLUSH_DEPTH=2 -> flush_if_id_o in cycles 5-6, flush_ie_o in cycle 5 only, RUN in cycle 7.
REQ-037 mc_start_i, then mc_done_i 10 cycles later -> 10 MC_WAIT cycles with bubble_imem_o=1; mc_done_i never asserted -> mc_timeout_o=1 after 40 cycles.
REQ-038 trap_i during MEM_WAIT -> no flush until rvalid, then flush_ie_o=1 in the first RUN cycle.
REQ-039 rst_ni low mid-MC_WAIT -> state_o=RUN and all outputs 0 immediately; stall_cnt_o held at 0xFFFF saturates under continued stalls.

Source files
------------

// File: rtl/common_pkg.sv
// Shared single-bit signal type used across pipeline control blocks.
package common_pkg;
  typedef enum logic {
    SIG_LOW  = 1'b0,
    SIG_HIGH = 1'b1
  } onebit_sig_e;
endpackage

// File: rtl/core_pkg.sv
// Core pipeline control types: hazard controller states and multicycle counter width.
package core_pkg;
  localparam int MC_CNT_W = 6;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } hc_state_e;
endpackage

// File: rtl/hc_sat_counter.sv
// Saturating up-counter for performance monitoring; sticks at all-ones.
// One-cycle update latency; no flow control.
module hc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush sequencing for memory, multicycle and redirect hazards.
// Outputs are combinational from state and inputs; redirects seen during a wait are deferred to the next RUN cycle.
module hazard_ctrl
  import core_pkg::*;
  import common_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned MC_TIMEOUT  = 40,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  onebit_sig_e       insert_bubble_i,
  input  logic              mc_start_i,
  input  logic              mc_done_i,
  input  logic              dmem_req_i,
  input  logic              dmem_we_i,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic              redirect_i,
  input  logic              trap_i,
  output logic              stall_if_o,
  output logic              stall_id_o,
  output logic              stall_ie_o,
  output logic              stall_imem_o,
  output logic              bubble_ie_o,
  output logic              bubble_imem_o,
  output logic              bubble_wb_o,
  output logic              flush_if_id_o,
  output logic              flush_ie_o,
  output hc_state_e         state_o,
  output logic              mc_timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [MC_CNT_W-1:0] MC_LAST    = MC_CNT_W'(MC_TIMEOUT - 1);

  hc_state_e           state_q, state_d;
  logic [2:0]          fcnt_q, fcnt_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                load_pend_q, trap_pend_q, redir_pend_q, mc_timeout_q;
  logic                set_timeout, pend_clr;
  logic                load_grant, mem_stall, mem_done, flush_req, in_wait;

  assign load_grant = dmem_req_i & dmem_gnt_i & ~dmem_we_i;
  // Either an ungranted request, or a load whose data did not follow its grant.
  assign mem_stall  = (dmem_req_i & ~dmem_gnt_i) | (load_pend_q & ~dmem_rvalid_i);
  assign mem_done   = load_pend_q ? dmem_rvalid_i : dmem_gnt_i;
  assign flush_req  = trap_i | redirect_i | trap_pend_q | redir_pend_q;
  assign in_wait    = (state_q == MEM_WAIT) || (state_q == MC_WAIT);

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    mc_cnt_d      = mc_cnt_q;
    set_timeout   = 1'b0;
    pend_clr      = 1'b0;
    stall_if_o    = 1'b0;
    stall_id_o    = 1'b0;
    stall_ie_o    = 1'b0;
    stall_imem_o  = 1'b0;
    bubble_ie_o   = 1'b0;
    bubble_imem_o = 1'b0;
    bubble_wb_o   = 1'b0;
    flush_if_id_o = 1'b0;
    flush_ie_o    = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        RUN: begin
          if (flush_req) begin
            flush_if_id_o = 1'b1;
            flush_ie_o    = 1'b1;
            pend_clr      = 1'b1;
            fcnt_d        = FLUSH_LOAD;
            if (FLUSH_DEPTH > 1) state_d = FLUSH;
          end else if (mem_stall) begin
            {stall_if_o, stall_id_o, stall_ie_o, stall_imem_o} = 4'b1111;
            bubble_wb_o = 1'b1;
            state_d     = MEM_WAIT;
          end else if (mc_start_i && !mc_done_i) begin
            mc_cnt_d = '0;
            state_d  = MC_WAIT;
          end else if (insert_bubble_i == SIG_HIGH) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ie_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_done) begin
            state_d = RUN;
          end else begin
            {stall_if_o, stall_id_o, stall_ie_o, stall_imem_o} = 4'b1111;
            bubble_wb_o = 1'b1;
          end
        end
        MC_WAIT: begin
          {stall_if_o, stall_id_o, stall_ie_o} = 3'b111;
          bubble_imem_o = 1'b1;
          mc_cnt_d      = mc_cnt_q + MC_CNT_W'(1);
          if (mc_done_i) begin
            state_d = RUN;
          end else if (mc_cnt_q == MC_LAST) begin
            set_timeout = 1'b1;
            state_d     = RUN;
          end
        end
        FLUSH: begin
          flush_if_id_o = 1'b1;
          // A trap mid-flush restarts the fetch-latency window.
          if (trap_i) begin
            flush_ie_o = 1'b1;
            fcnt_d     = FLUSH_LOAD;
          end else if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      fcnt_q       <= '0;
      mc_cnt_q     <= '0;
      load_pend_q  <= 1'b0;
      trap_pend_q  <= 1'b0;
      redir_pend_q <= 1'b0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      mc_cnt_q     <= mc_cnt_d;
      mc_timeout_q <= mc_timeout_q | set_timeout;
      if (load_grant) begin
        load_pend_q <= 1'b1;
      end else if (dmem_rvalid_i) begin
        load_pend_q <= 1'b0;
      end
      if (pend_clr) begin
        trap_pend_q  <= 1'b0;
        redir_pend_q <= 1'b0;
      end else if (in_wait) begin
        trap_pend_q  <= trap_pend_q | trap_i;
        redir_pend_q <= redir_pend_q | redirect_i;
      end
    end
  end

  assign state_o      = state_q;
  assign mc_timeout_o = mc_timeout_q;

  hc_sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (stall_if_o),
    .cnt_o  (stall_cnt_o)
  );

endmodule
